led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq.sv | 140 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances a SHIFT_L / SHIFT_R / BOUNCE / COUNT pattern on each synchronized slow_clk rising edge.
// Optional macro LEDSEQ_ACTIVE_LOW_EN drives led as the bitwise inverse of the pattern state.
module led_pattern_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  localparam logic [1:0] MODE_SHL    = 2'b00;
  localparam logic [1:0] MODE_SHR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  localparam logic [WIDTH-1:0] PAT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PAT_MSB = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef LEDSEQ_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] LED_RST = ~PAT_ONE;
`else
  localparam logic [WIDTH-1:0] LED_RST = PAT_ONE;
`endif

  logic             sync1_r, sync2_r, hist_r;
  logic             primed_r, armed_r, tick_r;
  logic [1:0]       mode_q;
  logic             dir_up_r, wrap_r;
  logic [WIDTH-1:0] pat_r, led_r;

  logic             reload_s, advance_s;
  logic [WIDTH-1:0] pat_step_s, pat_next_s, led_next_s;
  logic             dir_step_s, dir_next_s, wrap_next_s;

  function automatic logic [WIDTH-1:0] start_state(input logic [1:0] m);
    case (m)
      MODE_SHR:   start_state = PAT_MSB;
      MODE_COUNT: start_state = {WIDTH{1'b0}};
      default:    start_state = PAT_ONE;
    endcase
  endfunction

  // Slow clock synchronizer, history flop and rising-edge tick.
  // armed_r blocks a tick until a real low sample is seen, so a slow_clk
  // already high at reset release cannot masquerade as a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      hist_r   <= 1'b0;
      primed_r <= 1'b0;
      armed_r  <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      sync1_r  <= slow_clk;
      sync2_r  <= sync1_r;
      hist_r   <= sync2_r;
      primed_r <= 1'b1;
      armed_r  <= armed_r | (primed_r & ~sync1_r);
      tick_r   <= armed_r & sync2_r & ~hist_r;
    end
  end

  // Pattern state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_SHL;
      pat_r    <= PAT_ONE;
      dir_up_r <= 1'b1;
      wrap_r   <= 1'b0;
      led_r    <= LED_RST;
    end else begin
      mode_q   <= mode;
      pat_r    <= pat_next_s;
      dir_up_r <= dir_next_s;
      wrap_r   <= wrap_next_s;
      led_r    <= led_next_s;
    end
  end

  // One step of the active pattern.
  always_comb begin
    pat_step_s = pat_r;
    dir_step_s = dir_up_r;
    case (mode_q)
      MODE_SHL: pat_step_s = {pat_r[WIDTH-2:0], pat_r[WIDTH-1]};
      MODE_SHR: pat_step_s = {pat_r[0], pat_r[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // Direction flips on arriving at an end, so the ends are never repeated.
        if (dir_up_r) begin
          pat_step_s = {pat_r[WIDTH-2:0], 1'b0};
          dir_step_s = ~pat_step_s[WIDTH-1];
        end else begin
          pat_step_s = {1'b0, pat_r[WIDTH-1:1]};
          dir_step_s = pat_step_s[0];
        end
      end
      MODE_COUNT: pat_step_s = pat_r + PAT_ONE;
      default:    pat_step_s = pat_r;
    endcase
  end

  // Next-state selection: reload beats advance, pause freezes.
  always_comb begin
    reload_s    = (mode != mode_q);
    advance_s   = tick_r & ~pause;
    pat_next_s  = pat_r;
    dir_next_s  = dir_up_r;
    wrap_next_s = 1'b0;
    if (reload_s) begin
      pat_next_s = start_state(mode);
      dir_next_s = 1'b1;
    end else if (advance_s) begin
      pat_next_s  = pat_step_s;
      dir_next_s  = dir_step_s;
      wrap_next_s = (pat_step_s == start_state(mode_q));
    end else begin
      pat_next_s = pat_r;
      dir_next_s = dir_up_r;
    end
  end

  // LED drive polarity.
  always_comb begin
`ifdef LEDSEQ_ACTIVE_LOW_EN
    led_next_s = ~pat_next_s;
`else
    led_next_s = pat_next_s;
`endif
  end

  assign led  = led_r;
  assign tick = tick_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: vector table, hand-written corner sequences
// and randomized pulses against a position-based reference model.
module tb_led_pattern_seq;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         slow_clk;
  logic [1:0]   mode;
  logic         pause;
  logic [W-1:0] led;
  logic         tick;
  logic         wrap;

  int checks = 0;
  int passes = 0;
  logic [1:0] cur_mode;
  int k;

  led_pattern_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .mode(mode),
    .pause(pause), .led(led), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] led;
    logic         wrap;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  function automatic logic [W-1:0] disp(input logic [W-1:0] p);
`ifdef LEDSEQ_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // Pattern after k advances from the start state, from position arithmetic.
  function automatic logic [W-1:0] model_pat(input logic [1:0] m, input int n);
    logic [W-1:0] one = 1;
    int p;
    case (m)
      2'b00: return one << (n % W);
      2'b01: return one << (W - 1 - (n % W));
      2'b10: begin
        p = n % (2 * W - 2);
        return one << ((p < W) ? p : (2 * W - 2 - p));
      end
      default: return W'(n % (1 << W));
    endcase
  endfunction

  function automatic int period(input logic [1:0] m);
    case (m)
      2'b00, 2'b01: return W;
      2'b10:        return 2 * W - 2;
      default:      return 1 << W;
    endcase
  endfunction

  task automatic switch_mode(input logic [1:0] m);
    @(negedge clk);
    mode = m;
    @(posedge clk); #1;
    check("reload_led", led, disp(model_pat(m, 0)));
    check("reload_wrap", wrap, 0);
    cur_mode = m;
    k = 0;
  endtask

  // One slow_clk pulse held for 'hold' clk edges, then low for 'low' edges.
  task automatic do_pulse(input int hold, input int low, output logic [W-1:0] led_s, output logic wrap_s);
    int extra = 0;
    @(negedge clk);
    slow_clk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("tick_latency", tick, (i == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    led_s  = led;
    wrap_s = wrap;
    check("tick_width", tick, 0);
    @(posedge clk); #1;
    check("wrap_width", wrap, 0);
    if (tick) extra++;
    repeat (hold - 5) begin
      @(posedge clk); #1;
      if (tick) extra++;
    end
    @(negedge clk);
    slow_clk = 1'b0;
    repeat (low) begin
      @(posedge clk); #1;
      if (tick) extra++;
    end
    check("tick_once", extra, 0);
  endtask

  initial begin
    logic [W-1:0] l, exp_led;
    logic w;
    int wraps, extra;
    logic [1:0] m;

    vecs[0]  = '{2'b00, 6'b000010, 1'b0};
    vecs[1]  = '{2'b00, 6'b000100, 1'b0};
    vecs[2]  = '{2'b00, 6'b001000, 1'b0};
    vecs[3]  = '{2'b00, 6'b010000, 1'b0};
    vecs[4]  = '{2'b00, 6'b100000, 1'b0};
    vecs[5]  = '{2'b00, 6'b000001, 1'b1};
    vecs[6]  = '{2'b00, 6'b000010, 1'b0};
    vecs[7]  = '{2'b10, 6'b000010, 1'b0};
    vecs[8]  = '{2'b10, 6'b000100, 1'b0};
    vecs[9]  = '{2'b10, 6'b001000, 1'b0};
    vecs[10] = '{2'b10, 6'b010000, 1'b0};
    vecs[11] = '{2'b10, 6'b100000, 1'b0};
    vecs[12] = '{2'b10, 6'b010000, 1'b0};
    vecs[13] = '{2'b10, 6'b001000, 1'b0};
    vecs[14] = '{2'b10, 6'b000100, 1'b0};
    vecs[15] = '{2'b10, 6'b000010, 1'b0};
    vecs[16] = '{2'b10, 6'b000001, 1'b1};
    vecs[17] = '{2'b10, 6'b000010, 1'b0};

    rst = 1'b0; slow_clk = 1'b0; mode = 2'b00; pause = 1'b0;
    cur_mode = 2'b00; k = 0;
    #12;
    check("rst_led", led, disp(6'b000001));
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_led", led, disp(6'b000001));

    // Fixed vectors: shift-left wrap and bounce sequence
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].mode != cur_mode) switch_mode(vecs[i].mode);
      do_pulse(6, 4, l, w);
      k++;
      check("vec_led", l, disp(vecs[i].led));
      check("vec_wrap", w, vecs[i].wrap);
    end

    // Full COUNT cycle: single wrap at zero
    switch_mode(2'b11);
    wraps = 0;
    for (int i = 0; i < 64; i++) begin
      do_pulse(5, 3, l, w);
      k++;
      check("count_led", l, disp(model_pat(2'b11, k)));
      if (w) wraps++;
    end
    check("count_wraps", wraps, 1);
    check("count_end", l, disp(6'b000000));

    // Long slow_clk high gives a single tick
    do_pulse(100, 4, l, w);
    k++;
    check("long_hold_led", l, disp(model_pat(2'b11, k)));

    // Pause holds led while ticks continue; mode change still reloads
    switch_mode(2'b00);
    repeat (2) begin
      do_pulse(6, 4, l, w);
      k++;
    end
    check("pre_pause_led", l, disp(6'b000100));
    pause = 1'b1;
    repeat (3) begin
      do_pulse(6, 4, l, w);
      check("pause_led", l, disp(6'b000100));
      check("pause_wrap", w, 0);
    end
    switch_mode(2'b01);
    check("pause_reload_led", led, disp(6'b100000));
    pause = 1'b0;

    // Reload coinciding with tick: reload wins, no advance
    do_pulse(6, 4, l, w);
    k++;
    check("shr_step", l, disp(6'b010000));
    @(negedge clk);
    slow_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("coinc_tick", tick, 1);
    @(negedge clk);
    mode = 2'b11;
    @(posedge clk); #1;
    check("coinc_led", led, disp(6'b000000));
    check("coinc_wrap", wrap, 0);
    cur_mode = 2'b11; k = 0;
    @(negedge clk);
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);
    do_pulse(6, 4, l, w);
    k++;
    check("coinc_next", l, disp(6'b000001));

    // Randomized pulses, pauses and mode switches against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        m = 2'(cur_mode + 2'(1 + $urandom_range(0, 2)));
        switch_mode(m);
      end
      pause = ($urandom_range(0, 3) == 0);
      exp_led = model_pat(cur_mode, k);
      do_pulse(5 + $urandom_range(0, 3), 3 + $urandom_range(0, 3), l, w);
      if (!pause) begin
        k++;
        exp_led = model_pat(cur_mode, k);
        check("rand_led", l, disp(exp_led));
        check("rand_wrap", w, (k % period(cur_mode) == 0) ? 1 : 0);
      end else begin
        check("rand_pause_led", l, disp(exp_led));
        check("rand_pause_wrap", w, 0);
      end
    end
    pause = 1'b0;

    // Asynchronous reset mid-pattern while tick is high
    if (cur_mode != 2'b00) switch_mode(2'b00);
    do_pulse(6, 4, l, w);
    k++;
    check("pre_rst_led", l, disp(model_pat(2'b00, k)));
    @(negedge clk);
    slow_clk = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_tick", tick, 1);
    rst = 1'b0;
    #1;
    check("async_rst_led", led, disp(6'b000001));
    check("async_rst_tick", tick, 0);
    check("async_rst_wrap", wrap, 0);
    mode = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_led", led, disp(6'b000001));

    // Release with slow_clk high and mode != 00
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("release_reload", led, disp(6'b100000));
    check("release_wrap", wrap, 0);
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tick) extra++;
    end
    check("release_no_tick", extra, 0);
    @(negedge clk);
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);
    cur_mode = 2'b01; k = 0;
    do_pulse(6, 4, l, w);
    k++;
    check("post_release_led", l, disp(6'b010000));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
